guess_evaluator: RTL and testbench

- Sequences the scoring of one submitted Wordle row.
- Captures the 5-cell row from the selection stage on its one-cycle submit pulse.
- Scores each cell against the answer word (green/yellow/grey) with correct duplicate-letter handling.
- Writes the coloured cells one per cycle into the board store, then advances the active row and flags win or loss.

---
 rtl/wordle_pkg.sv | 33 +++
 rtl/letter_count_bank.sv | 39 +++
 rtl/guess_evaluator.sv | 176 +++++++++++++++++
 tb/tb_guess_evaluator.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wordle_pkg.sv
// Shared types and constants for the Wordle row scorer.
// Cell layout is {color[1:0], letter[4:0]}. Letters run A=0..Z=25,
// and 26 means blank.
package wordle_pkg;
  localparam int LETTER_W    = 5;
  localparam int CELL_W      = 7;
  localparam int NUM_COLS    = 5;
  localparam int NUM_LETTERS = 26;
  localparam int CNT_W       = 3;

  localparam logic [LETTER_W-1:0] LETTER_BLANK = 5'd26;

  localparam logic [1:0] COLOR_GREY   = 2'd0;
  localparam logic [1:0] COLOR_YELLOW = 2'd1;
  localparam logic [1:0] COLOR_GREEN  = 2'd2;
  localparam logic [1:0] COLOR_RED    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_GREEN, S_YELLOW, S_WRITE, S_FINISH, S_GAME_OVER
  } state_t;

  typedef struct packed {
    logic [1:0]          color;
    logic [LETTER_W-1:0] letter;
  } cell_t;

  function automatic logic has_blank(input logic [NUM_COLS-1:0][LETTER_W-1:0] l);
    logic b;
    b = 1'b0;
    for (int c = 0; c < NUM_COLS; c++) b |= (l[c] == LETTER_BLANK);
    return b;
  endfunction
endpackage

// File: rtl/letter_count_bank.sv
// Bank of 26 small letter counters used for yellow-letter accounting.
// Ports: clk/clr_n (async low reset), clr (sync clear of every counter),
//   inc/inc_idx and dec/dec_idx (single-counter bump), look_idx ->
//   nonzero (combinational "count > 0"; any index >= 26, including
//   blank, reads as zero).
module letter_count_bank
  import wordle_pkg::*;
(
  input  logic                clk,
  input  logic                clr_n,
  input  logic                clr,
  input  logic                inc,
  input  logic [LETTER_W-1:0] inc_idx,
  input  logic                dec,
  input  logic [LETTER_W-1:0] dec_idx,
  input  logic [LETTER_W-1:0] look_idx,
  output logic                nonzero
);
  logic [CNT_W-1:0] cnt [NUM_LETTERS];

  // A counter can only reach 5 (one per answer column), so 3 bits
  // never wrap. The scorer only decrements after a nonzero lookup.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NUM_LETTERS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LETTERS; i++) begin
        if (clr)                                    cnt[i] <= '0;
        else if (inc && inc_idx == LETTER_W'(i))    cnt[i] <= cnt[i] + 1'b1;
        else if (dec && dec_idx == LETTER_W'(i))    cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    nonzero = 1'b0;
    if (look_idx < LETTER_W'(NUM_LETTERS)) nonzero = |cnt[look_idx];
  end
endmodule

// File: rtl/guess_evaluator.sv
// Scores one submitted Wordle row and writes the coloured cells to the board.
// Flow: IDLE -> GREEN(5) -> YELLOW(5) -> WRITE(5) -> FINISH -> IDLE/GAME_OVER.
// Ports: clk, clr_n (async low reset); submitted/row_values/answer capture
//   a guess; new_game restarts; wr_en/wr_row/wr_col/wr_value drive the
//   board store; row_index is the active row; eval_done pulses per row;
//   game_won/game_lost are sticky; busy covers every state but IDLE and
//   GAME_OVER.
// Option BLANK_REJECT_EN: a guess containing a blank is written back
//   all-red without scoring, and row_index does not advance.
module guess_evaluator
  import wordle_pkg::*;
#(
  parameter int NUM_ROWS = 6
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       submitted,
  input  logic [NUM_COLS*CELL_W-1:0] row_values,
  input  logic [NUM_COLS*LETTER_W-1:0] answer,
  input  logic                       new_game,
  output logic                       busy,
  output logic                       wr_en,
  output logic [2:0]                 wr_row,
  output logic [2:0]                 wr_col,
  output logic [CELL_W-1:0]          wr_value,
  output logic [2:0]                 row_index,
  output logic                       eval_done,
  output logic                       game_won,
  output logic                       game_lost
);
  state_t                            state;
  logic [2:0]                        col;
  logic [NUM_COLS-1:0][LETTER_W-1:0] row_letters, guess, ans;
  logic [NUM_COLS-1:0][1:0]          color;
  logic                              all_green;
  logic                              cnt_clr, cnt_inc, cnt_dec, cnt_nz;
`ifdef BLANK_REJECT_EN
  logic                              reject;
`endif

  // Colour bits of the incoming row are dropped; only letters are scored.
  always_comb begin
    all_green = 1'b1;
    for (int c = 0; c < NUM_COLS; c++) begin
      row_letters[c] = row_values[CELL_W*c +: LETTER_W];
      all_green &= (color[c] == COLOR_GREEN);
    end
  end

  // Pass 1 counts unmatched answer letters; pass 2 spends them left to
  // right, so surplus duplicates in the guess stay grey.
  assign cnt_clr = (state == S_IDLE);
  assign cnt_inc = (state == S_GREEN) && (guess[col] != ans[col]);
  assign cnt_dec = (state == S_YELLOW) && (color[col] != COLOR_GREEN) && cnt_nz;

  letter_count_bank u_cnt (
    .clk      (clk),
    .clr_n    (clr_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .inc_idx  (ans[col]),
    .dec      (cnt_dec),
    .dec_idx  (guess[col]),
    .look_idx (guess[col]),
    .nonzero  (cnt_nz)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      col       <= '0;
      guess     <= '0;
      ans       <= '0;
      color     <= '0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_row    <= '0;
      wr_col    <= '0;
      wr_value  <= '0;
      row_index <= '0;
      eval_done <= 1'b0;
      game_won  <= 1'b0;
      game_lost <= 1'b0;
`ifdef BLANK_REJECT_EN
      reject    <= 1'b0;
`endif
    end else if (new_game) begin
      state     <= S_IDLE;
      col       <= '0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      eval_done <= 1'b0;
      row_index <= '0;
      game_won  <= 1'b0;
      game_lost <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (submitted) begin
          guess <= row_letters;
          ans   <= answer;
          col   <= '0;
          busy  <= 1'b1;
`ifdef BLANK_REJECT_EN
          reject <= has_blank(row_letters);
          if (has_blank(row_letters)) begin
            color    <= {NUM_COLS{COLOR_RED}};
            state    <= S_WRITE;
            wr_en    <= 1'b1;
            wr_row   <= row_index;
            wr_col   <= '0;
            wr_value <= {COLOR_RED, row_letters[0]};
          end else begin
            color <= '0;
            state <= S_GREEN;
          end
`else
          color <= '0;
          state <= S_GREEN;
`endif
        end
        S_GREEN: begin
          if (guess[col] == ans[col]) color[col] <= COLOR_GREEN;
          if (col == 3'd4) begin
            col   <= '0;
            state <= S_YELLOW;
          end else col <= col + 3'd1;
        end
        S_YELLOW: begin
          if (cnt_dec) color[col] <= COLOR_YELLOW;
          if (col == 3'd4) begin
            // Column 0 colour is already final here, so the first write
            // can be staged on this edge.
            col      <= '0;
            state    <= S_WRITE;
            wr_en    <= 1'b1;
            wr_row   <= row_index;
            wr_col   <= '0;
            wr_value <= {color[0], guess[0]};
          end else col <= col + 3'd1;
        end
        S_WRITE: begin
          if (col == 3'd4) begin
            col       <= '0;
            wr_en     <= 1'b0;
            eval_done <= 1'b1;
            state     <= S_FINISH;
          end else begin
            col      <= col + 3'd1;
            wr_col   <= col + 3'd1;
            wr_value <= {color[col + 3'd1], guess[col + 3'd1]};
          end
        end
        S_FINISH: begin
          eval_done <= 1'b0;
          busy      <= 1'b0;
`ifdef BLANK_REJECT_EN
          if (reject) state <= S_IDLE;
          else
`endif
          if (all_green) begin
            game_won <= 1'b1;
            state    <= S_GAME_OVER;
          end else if (row_index == 3'(NUM_ROWS - 1)) begin
            game_lost <= 1'b1;
            state     <= S_GAME_OVER;
          end else begin
            row_index <= row_index + 3'd1;
            state     <= S_IDLE;
          end
        end
        S_GAME_OVER: state <= S_GAME_OVER;
        default:     state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_guess_evaluator.sv
module tb_guess_evaluator;
  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        submitted = 1'b0;
  logic [34:0] row_values = '0;
  logic [24:0] answer = '0;
  logic        new_game = 1'b0;
  logic        busy, wr_en, eval_done, game_won, game_lost;
  logic [2:0]  wr_row, wr_col, row_index;
  logic [6:0]  wr_value;

  int checks = 0;
  int errors = 0;

  // per-row observations
  int         nwr, first_wr, last_wr, done_k, ndone, busy1, wrow0;
  logic [6:0] wv [5];
  logic [2:0] wc [5];

  guess_evaluator #(.NUM_ROWS(6)) dut (
    .clk(clk), .clr_n(clr_n), .submitted(submitted), .row_values(row_values),
    .answer(answer), .new_game(new_game), .busy(busy), .wr_en(wr_en),
    .wr_row(wr_row), .wr_col(wr_col), .wr_value(wr_value),
    .row_index(row_index), .eval_done(eval_done),
    .game_won(game_won), .game_lost(game_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // '_' is a blank cell; colour bits are set to 3 to show they are ignored
  function automatic logic [4:0] ltr(input byte ch);
    return (ch == "_") ? 5'd26 : 5'(ch - 8'd65);
  endfunction

  function automatic logic [24:0] word(input string s);
    logic [24:0] w;
    for (int i = 0; i < 5; i++) w[5*i +: 5] = ltr(s[i]);
    return w;
  endfunction

  function automatic logic [34:0] row(input string s);
    logic [34:0] r;
    for (int i = 0; i < 5; i++) r[7*i +: 7] = {2'b11, ltr(s[i])};
    return r;
  endfunction

  // Pulse submit; k counts cycles after the sampling edge T, observed at
  // the negedge after edge T+k-1. Optional extra submit / new_game at k.
  task automatic do_row(input string g, input string a, input int sub2_k, input int ng_k);
    nwr = 0; first_wr = 0; last_wr = 0; done_k = 0; ndone = 0; busy1 = 0; wrow0 = 0;
    for (int i = 0; i < 5; i++) begin wv[i] = '0; wc[i] = '0; end
    @(negedge clk);
    row_values = row(g);
    answer     = word(a);
    submitted  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      submitted = (k == sub2_k);
      new_game  = (k == ng_k);
      if (k == 1) busy1 = busy;
      if (wr_en) begin
        if (nwr < 5) begin
          wv[nwr] = wr_value;
          wc[nwr] = wr_col;
        end
        if (nwr == 0) begin first_wr = k; wrow0 = wr_row; end
        last_wr = k;
        nwr++;
      end
      if (eval_done) begin
        if (ndone == 0) done_k = k;
        ndone++;
      end
    end
    @(negedge clk);
    submitted = 1'b0;
    new_game  = 1'b0;
  endtask

  task automatic pulse_new_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_row_index", row_index, 0);
    check("rst_outs", {eval_done, game_won, game_lost, wr_row, wr_col, wr_value}, 0);
    @(negedge clk); clr_n = 1'b1;

    // APPLE / PAPPY: duplicate handling
    do_row("PAPPY", "APPLE", 0, 0);
    check("apple_busy1", busy1, 1);
    check("apple_nwr", nwr, 5);
    check("apple_first_wr", first_wr, 11);
    check("apple_wr_row", wrow0, 0);
    check("apple_v0", wv[0], 7'h2F);
    check("apple_v1", wv[1], 7'h20);
    check("apple_v2", wv[2], 7'h4F);
    check("apple_v3", wv[3], 7'h0F);
    check("apple_v4", wv[4], 7'h18);
    check("apple_cols", {wc[0], wc[1], wc[2], wc[3], wc[4]}, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
    check("apple_done_k", done_k, 16);
    check("apple_row_index", row_index, 1);
    check("apple_won", game_won, 0);

    // second submit mid-evaluation is dropped
    do_row("SLATE", "CRANE", 3, 0);
    check("mid_nwr", nwr, 5);
    check("mid_ndone", ndone, 1);
    check("mid_row_index", row_index, 2);

    // new_game at T+12 aborts the write phase
    do_row("SLATE", "CRANE", 0, 12);
    check("ng_nwr", nwr, 2);
    check("ng_last_wr", last_wr, 12);
    check("ng_ndone", ndone, 0);
    check("ng_row_index", row_index, 0);
    check("ng_busy", busy, 0);

    // CRANE / CRANE wins
    do_row("CRANE", "CRANE", 0, 0);
    check("win_nwr", nwr, 5);
    check("win_vals", {wv[0], wv[1], wv[2], wv[3], wv[4]},
          {7'h42, 7'h51, 7'h40, 7'h4D, 7'h44});
    check("win_done_k", done_k, 16);
    check("win_won", game_won, 1);
    check("win_busy", busy, 0);
    do_row("CRANE", "CRANE", 0, 0);
    check("over_nwr", nwr, 0);
    check("over_ndone", ndone, 0);

    // six wrong guesses lose
    pulse_new_game();
    check("ng_won_clr", game_won, 0);
    do_row("HOUSE", "CRANE", 0, 0);
    do_row("PLANT", "CRANE", 0, 0);
    do_row("MOIST", "CRANE", 0, 0);
    do_row("BUDDY", "CRANE", 0, 0);
    do_row("GHOST", "CRANE", 0, 0);
    check("lose_row5", row_index, 5);
    check("lose_not_yet", game_lost, 0);
    do_row("FLING", "CRANE", 0, 0);
    check("lose_ndone", ndone, 1);
    check("lose_lost", game_lost, 1);
    check("lose_row_index", row_index, 5);
    check("lose_busy", busy, 0);
    do_row("CRANE", "CRANE", 0, 0);
    check("lose_7th_nwr", nwr, 0);
    check("lose_7th_won", game_won, 0);

    // blank letter at column 2
    pulse_new_game();
    do_row("CR_NE", "CRANE", 0, 0);
    check("blank_nwr", nwr, 5);
`ifdef BLANK_REJECT_EN
    check("blank_vals", {wv[0], wv[1], wv[2], wv[3], wv[4]},
          {7'h62, 7'h71, 7'h7A, 7'h6D, 7'h64});
    check("blank_first_wr", first_wr, 1);
    check("blank_done_k", done_k, 6);
    check("blank_row_index", row_index, 0);
`else
    check("blank_vals", {wv[0], wv[1], wv[2], wv[3], wv[4]},
          {7'h42, 7'h51, 7'h1A, 7'h4D, 7'h44});
    check("blank_done_k", done_k, 16);
    check("blank_row_index", row_index, 1);
`endif

    // asynchronous reset at T+8
    @(negedge clk);
    row_values = row("SLATE");
    answer     = word("CRANE");
    submitted  = 1'b1;
    @(negedge clk);
    submitted = 1'b0;
    repeat (7) @(negedge clk);
    check("arst_busy_before", busy, 1);
    clr_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_row_index", row_index, 0);
    check("arst_outs", {wr_en, eval_done, game_won, game_lost, wr_row, wr_col, wr_value}, 0);
    @(negedge clk); clr_n = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_stays_idle", {busy, wr_en, eval_done}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
